// File: rtl/microc_pkg.sv
// rtl/microc_pkg.sv - shared ALU opcodes and opcode width for the microcontroller datapath
package microc_pkg;

  localparam int OPW = 6;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_NOT  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_NEGA = 3'b110;
  localparam logic [2:0] ALU_NEGB = 3'b111;

endpackage

// File: rtl/microc_stack.sv
// rtl/microc_stack.sv - parametrised return-address LIFO; push on full and pop on empty are ignored
module microc_stack #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int SPW  = $clog2(DEPTH + 1);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] ONE    = SPW'(1);
  localparam logic [SPW-1:0] FULL_V = SPW'(DEPTH);

  logic [W-1:0]   mem [2**IDXW];
  logic [SPW-1:0] sp;

  assign full  = (sp == FULL_V);
  assign empty = (sp == '0);
  // sp points one past the newest entry
  assign top   = mem[IDXW'(sp - ONE)];

  always_ff @(posedge clk) begin
    if (!reset && push && !full) begin
      mem[IDXW'(sp)] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + ONE;
    end else if (pop && !empty) begin
      sp <= sp - ONE;
    end
  end

endmodule

// File: rtl/microc_dp_param.sv
// rtl/microc_dp_param.sv - microcontroller datapath with return stack; CARRY_FLAG_EN enables the carry flag
module microc_dp_param
  import microc_pkg::*;
#(
  parameter int DW     = 8,
  parameter int RA     = 4,
  parameter int PCW    = 10,
  parameter int SDEPTH = 4,
  parameter int IW     = 6 + DW + RA
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_inc,
  input  logic           s_inm,
  input  logic           we3,
  input  logic [2:0]     op,
  input  logic           s_call,
  input  logic           s_ret,
  input  logic [IW-1:0]  instr,
  output logic [PCW-1:0] pc,
  output logic [OPW-1:0] opcode,
  output logic           z,
  output logic           c,
  output logic           stk_err
);

  logic [DW-1:0]  imm, a, b, alu_y, wd3, sum, dif;
  logic [RA-1:0]  wa3, ra1, ra2;
  logic [PCW-1:0] jaddr, pc_inc, stk_top;
  logic           stk_full, stk_empty, push, pop;
  logic [DW-1:0]  rf [2**RA];

  assign opcode = instr[IW-1:IW-OPW];
  assign imm    = instr[RA+DW-1:RA];
  assign wa3    = instr[RA-1:0];
  assign ra1    = instr[3*RA-1:2*RA];
  assign ra2    = instr[2*RA-1:RA];
  assign jaddr  = instr[PCW-1:0];

  assign a   = (ra1 == '0) ? '0 : rf[ra1];
  assign b   = (ra2 == '0) ? '0 : rf[ra2];
  assign wd3 = s_inm ? imm : alu_y;

  always_ff @(posedge clk) begin
    if (!reset && we3 && (wa3 != '0)) begin
      rf[wa3] <= wd3;
    end
  end

`ifdef CARRY_FLAG_EN
  logic [DW:0] add_w, sub_w;
  logic        carry;
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign sum   = add_w[DW-1:0];
  assign dif   = sub_w[DW-1:0];
  // the extra MSB of a zero-extended subtract is the borrow
  assign carry = (op == ALU_ADD) ? add_w[DW] : (op == ALU_SUB) ? sub_w[DW] : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      c <= 1'b0;
    end else if (we3 && !s_inm) begin
      c <= carry;
    end
  end
`else
  assign sum = a + b;
  assign dif = a - b;
  assign c   = 1'b0;
`endif

  always_comb begin
    alu_y = a;
    case (op)
      ALU_PASS: alu_y = a;
      ALU_NOT:  alu_y = ~a;
      ALU_ADD:  alu_y = sum;
      ALU_SUB:  alu_y = dif;
      ALU_AND:  alu_y = a & b;
      ALU_OR:   alu_y = a | b;
      ALU_NEGA: alu_y = '0 - a;
      ALU_NEGB: alu_y = '0 - b;
      default:  alu_y = a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z <= 1'b0;
    end else if (we3 && !s_inm) begin
      z <= (alu_y == '0);
    end
  end

  assign pc_inc = pc + PCW'(1);
  assign push   = s_call && !s_ret && !stk_full;
  assign pop    = s_ret && !stk_empty;

  microc_stack #(.W(PCW), .DEPTH(SDEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .data  (pc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // return outranks call; a return on an empty stack falls through to pc+1
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (s_ret) begin
      pc <= stk_empty ? pc_inc : stk_top;
    end else if (s_call) begin
      pc <= jaddr;
    end else if (s_inc) begin
      pc <= pc_inc;
    end else begin
      pc <= jaddr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stk_err <= 1'b0;
    end else if ((s_ret && stk_empty) || (s_call && !s_ret && stk_full)) begin
      stk_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_microc_dp_param.sv
// tb/tb_microc_dp_param.sv - directed self-checking bench for microc_dp_param
module tb_microc_dp_param;

  logic        clk = 1'b0;
  logic        reset, s_inc, s_inm, we3, s_call, s_ret;
  logic [2:0]  op;
  logic [17:0] instr;
  logic [9:0]  pc;
  logic [5:0]  opcode;
  logic        z, c, stk_err;
  int          nchk = 0;
  int          nfail = 0;

`ifdef CARRY_FLAG_EN
  localparam logic CEXP = 1'b1;
`else
  localparam logic CEXP = 1'b0;
`endif

  microc_dp_param dut (
    .clk(clk), .reset(reset), .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .op(op),
    .s_call(s_call), .s_ret(s_ret), .instr(instr), .pc(pc), .opcode(opcode),
    .z(z), .c(c), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] ins(input logic [5:0] opc, input logic [7:0] im, input logic [3:0] wa);
    return {opc, im, wa};
  endfunction

  function automatic logic [17:0] alu_ins(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] wa);
    return {6'h00, r1, r2, wa};
  endfunction

  function automatic logic [17:0] jmp(input logic [9:0] addr);
    return {8'h00, addr};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic inc, input logic inm, input logic we, input logic [2:0] o,
                       input logic call, input logic ret, input logic [17:0] in);
    s_inc = inc; s_inm = inm; we3 = we; op = o; s_call = call; s_ret = ret; instr = in;
    cyc();
  endtask

  task automatic load(input logic [3:0] wa, input logic [7:0] v);
    drive(1, 1, 1, 3'b000, 0, 0, ins(6'h00, v, wa));
  endtask

  task automatic alu(input logic [2:0] o, input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] wa);
    drive(1, 0, 1, o, 0, 0, alu_ins(r1, r2, wa));
  endtask

  task automatic test_reset();
    reset = 1; s_inc = 0; s_inm = 0; we3 = 0; op = 0; s_call = 1; s_ret = 0; instr = jmp(10'h077);
    cyc();
    reset = 0; s_call = 0;
    nchk++; if (pc !== 10'h000) begin nfail++; $display("FAIL reset_pc: got %h want 000", pc); end
    nchk++; if ({z, c, stk_err} !== 3'b000) begin nfail++; $display("FAIL reset_flags: got z%b c%b e%b want 000", z, c, stk_err); end
  endtask

  task automatic test_load_imm();
    s_inc = 1; s_inm = 1; we3 = 1; op = 0; instr = ins(6'h2B, 8'h2A, 4'h3);
    #1;
    nchk++; if (opcode !== 6'h2B) begin nfail++; $display("FAIL opcode_comb: got %h want 2b", opcode); end
    cyc();
    nchk++; if (pc !== 10'h001) begin nfail++; $display("FAIL load_pc: got %h want 001", pc); end
    nchk++; if (z !== 1'b0) begin nfail++; $display("FAIL load_z_hold: got %b want 0", z); end
    load(4'h4, 8'h2A);
    alu(3'b011, 4'h3, 4'h4, 4'h5);
    nchk++; if (z !== 1'b1) begin nfail++; $display("FAIL r3_value: z got %b want 1", z); end
    load(4'h1, 8'h05);
    nchk++; if (z !== 1'b1) begin nfail++; $display("FAIL imm_z_hold: got %b want 1", z); end
    load(4'h2, 8'h05);
    alu(3'b000, 4'h3, 4'h0, 4'h5);
    nchk++; if (z !== 1'b0) begin nfail++; $display("FAIL pass_nonzero: z got %b want 0", z); end
  endtask

  task automatic test_alu();
    alu(3'b011, 4'h1, 4'h2, 4'h6);
    nchk++; if (z !== 1'b1) begin nfail++; $display("FAIL sub_equal: z got %b want 1", z); end
    nchk++; if (c !== 1'b0) begin nfail++; $display("FAIL sub_noborrow: c got %b want 0", c); end
    alu(3'b010, 4'h1, 4'h2, 4'h6);
    nchk++; if (z !== 1'b0) begin nfail++; $display("FAIL add_5_5: z got %b want 0", z); end
    load(4'h7, 8'h0A);
    alu(3'b011, 4'h6, 4'h7, 4'h5);
    nchk++; if (z !== 1'b1) begin nfail++; $display("FAIL add_result_0a: z got %b want 1", z); end
    drive(1, 0, 0, 3'b000, 0, 0, alu_ins(4'h3, 4'h0, 4'h5));
    nchk++; if (z !== 1'b1) begin nfail++; $display("FAIL we3_low_hold: z got %b want 1", z); end
    load(4'h8, 8'h15);
    alu(3'b100, 4'h3, 4'h8, 4'h5);
    nchk++; if (z !== 1'b1) begin nfail++; $display("FAIL and_disjoint: z got %b want 1", z); end
    alu(3'b101, 4'h3, 4'h8, 4'h5);
    nchk++; if (z !== 1'b0) begin nfail++; $display("FAIL or_nonzero: z got %b want 0", z); end
    load(4'h0, 8'h55);
    alu(3'b000, 4'h0, 4'h0, 4'h5);
    nchk++; if (z !== 1'b1) begin nfail++; $display("FAIL r0_zero: z got %b want 1", z); end
    load(4'h9, 8'h01);
    alu(3'b110, 4'h9, 4'h0, 4'hA);
    alu(3'b010, 4'hA, 4'h9, 4'h5);
    nchk++; if (z !== 1'b1) begin nfail++; $display("FAIL nega_plus_a: z got %b want 1", z); end
    alu(3'b001, 4'h0, 4'h0, 4'h5);
    nchk++; if (z !== 1'b0) begin nfail++; $display("FAIL not_zero: z got %b want 0", z); end
  endtask

  task automatic test_carry();
    load(4'h1, 8'hFF);
    load(4'h2, 8'h01);
    alu(3'b010, 4'h1, 4'h2, 4'h5);
    nchk++; if (z !== 1'b1) begin nfail++; $display("FAIL carry_add_z: got %b want 1", z); end
    nchk++; if (c !== CEXP) begin nfail++; $display("FAIL carry_add_c: got %b want %b", c, CEXP); end
    alu(3'b011, 4'h2, 4'h1, 4'h5);
    nchk++; if ({z, c} !== {1'b0, CEXP}) begin nfail++; $display("FAIL borrow_sub: got z%b c%b want z0 c%b", z, c, CEXP); end
    alu(3'b011, 4'h1, 4'h2, 4'h5);
    nchk++; if (c !== 1'b0) begin nfail++; $display("FAIL sub_noborrow_ff: c got %b want 0", c); end
    alu(3'b010, 4'h1, 4'h2, 4'h5);
    alu(3'b000, 4'h1, 4'h0, 4'h5);
    nchk++; if (c !== 1'b0) begin nfail++; $display("FAIL pass_clears_c: got %b want 0", c); end
  endtask

  task automatic test_jump();
    drive(0, 0, 0, 3'b000, 0, 0, {6'h3F, 2'b11, 10'h155});
    nchk++; if (pc !== 10'h155) begin nfail++; $display("FAIL jump_155: got %h want 155", pc); end
    drive(0, 0, 0, 3'b000, 0, 0, jmp(10'h3FF));
    drive(1, 0, 0, 3'b000, 0, 0, jmp(10'h000));
    nchk++; if (pc !== 10'h000) begin nfail++; $display("FAIL pc_wrap: got %h want 000", pc); end
  endtask

  task automatic test_calls();
    drive(0, 0, 0, 3'b000, 0, 0, jmp(10'h005));
    drive(1, 0, 0, 3'b000, 1, 0, jmp(10'h020));
    nchk++; if (pc !== 10'h020) begin nfail++; $display("FAIL call1: got %h want 020", pc); end
    drive(1, 0, 0, 3'b000, 1, 0, jmp(10'h100));
    nchk++; if (pc !== 10'h100) begin nfail++; $display("FAIL call2: got %h want 100", pc); end
    drive(1, 0, 0, 3'b000, 0, 0, jmp(10'h000));
    drive(1, 0, 0, 3'b000, 0, 1, jmp(10'h000));
    nchk++; if (pc !== 10'h021) begin nfail++; $display("FAIL ret1: got %h want 021", pc); end
    drive(1, 0, 0, 3'b000, 0, 1, jmp(10'h000));
    nchk++; if (pc !== 10'h006) begin nfail++; $display("FAIL ret2: got %h want 006", pc); end
    nchk++; if (stk_err !== 1'b0) begin nfail++; $display("FAIL nested_err: got %b want 0", stk_err); end
  endtask

  task automatic test_overflow();
    logic [9:0] rets [4] = '{10'h061, 10'h051, 10'h041, 10'h011};
    drive(0, 0, 0, 3'b000, 0, 0, jmp(10'h010));
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 3'b000, 1, 0, jmp(10'h040 + 10'(i * 16)));
      if (i == 3) begin
        nchk++; if (stk_err !== 1'b0) begin nfail++; $display("FAIL full_no_err: got %b want 0", stk_err); end
      end
    end
    nchk++; if (pc !== 10'h080) begin nfail++; $display("FAIL overflow_pc: got %h want 080", pc); end
    nchk++; if (stk_err !== 1'b1) begin nfail++; $display("FAIL overflow_err: got %b want 1", stk_err); end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 3'b000, 0, 1, jmp(10'h000));
      nchk++; if (pc !== rets[i]) begin nfail++; $display("FAIL ret_%0d: got %h want %h", i, pc, rets[i]); end
    end
    drive(0, 0, 0, 3'b000, 0, 1, jmp(10'h2AA));
    nchk++; if (pc !== 10'h012) begin nfail++; $display("FAIL underflow_pc: got %h want 012", pc); end
    drive(1, 0, 0, 3'b000, 0, 0, jmp(10'h000));
    nchk++; if (stk_err !== 1'b1) begin nfail++; $display("FAIL err_sticky: got %b want 1", stk_err); end
  endtask

  task automatic test_back_to_back();
    reset = 1;
    cyc();
    reset = 0;
    nchk++; if ({pc, stk_err} !== 11'h000) begin nfail++; $display("FAIL reset_clears_err: got pc %h e%b want 000 e0", pc, stk_err); end
    drive(0, 0, 0, 3'b000, 0, 0, jmp(10'h030));
    drive(1, 1, 1, 3'b000, 1, 0, ins(6'h00, 8'h12, 4'h9));
    nchk++; if (pc !== 10'h129) begin nfail++; $display("FAIL call_with_write: got %h want 129", pc); end
    load(4'hA, 8'h12);
    alu(3'b011, 4'h9, 4'hA, 4'h5);
    nchk++; if (z !== 1'b1) begin nfail++; $display("FAIL write_during_call: z got %b want 1", z); end
    drive(1, 0, 0, 3'b000, 1, 1, jmp(10'h300));
    nchk++; if (pc !== 10'h031) begin nfail++; $display("FAIL call_ret_together: got %h want 031", pc); end
    drive(1, 0, 0, 3'b000, 0, 1, jmp(10'h000));
    nchk++; if ({pc, stk_err} !== {10'h032, 1'b1}) begin nfail++; $display("FAIL no_push_on_ret: got pc %h e%b want 032 e1", pc, stk_err); end
  endtask

  initial begin
    test_reset();
    test_load_imm();
    test_alu();
    test_carry();
    test_jump();
    test_calls();
    test_overflow();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/microc_dp_param.md
Name: microc_dp_param

Overview:
Parametrised next-generation microcontroller datapath: PC, register file, ALU, zero flag, plus a new hardware return-address stack for subroutine call/return.
- Driven cycle by cycle by the external control unit via s_inc/s_inm/we3/op, and new s_call/s_ret.
- Instruction memory is external: block drives pc, receives instr combinationally in the same cycle.
- Data width, register count, PC width and stack depth are parameters.

Parameters:
DW, 8, data/register width
RA, 4, register address width (2**RA registers, R0 hard-wired zero)
PCW, 10, program counter width; constraint PCW <= DW+RA
SDEPTH, 4, return-stack depth (>=1); constraint 2*RA <= DW
IW, 6+DW+RA, instruction width (derived, do not override)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
s_inc  in  1  1: next PC = pc+1; 0: next PC = jump field
s_inm  in  1  1: write-back data = immediate; 0: ALU result
we3  in  1  register file write enable
op  in  3  ALU operation
s_call  in  1  subroutine call
s_ret  in  1  subroutine return
instr  in  IW  instruction word at address pc
pc  out  PCW  program counter (registered)
opcode  out  6  instr[IW-1:IW-6], combinational
z  out  1  zero flag (registered)
c  out  1  carry flag (registered; see Optional Feature)
stk_err  out  1  sticky stack overflow/underflow error

Behaviour:
- Fields: imm = instr[RA+DW-1:RA]; wa3 = instr[RA-1:0]; ra1 = instr[3RA-1:2RA]; ra2 = instr[2RA-1:RA]; jaddr = instr[PCW-1:0].
- Reset (sync, same edge): pc=0, z=0, c=0, stk_err=0, stack pointer=0. Register contents are not reset. Reset overrides every other input.
- Register file: 2 combinational reads; R0 reads 0. Write at rising edge when we3=1 and wa3!=0. wd3 = s_inm ? imm : alu_y.
- ALU (A=R[ra1], B=R[ra2], result DW bits, wraps mod 2**DW):
  - 000 A; 001 ~A; 010 A+B; 011 A-B
  - 100 A&B; 101 A|B; 110 -A; 111 -B
- z <= (alu_y==0) only on edges with we3=1 and s_inm=0; otherwise holds.
- Next PC, priority high to low:
  - s_ret: pop top of stack.
  - s_call: jaddr; push pc+1.
  - s_inc=1: pc+1 (wraps 2**PCW-1 -> 0).
  - else: jaddr.
- s_call and s_ret together: ret wins, call ignored (no push).
- Push when full (SDEPTH entries): stack unchanged, PC still jumps to jaddr, stk_err <= 1.
- Pop when empty: PC <= pc+1, stk_err <= 1.
- stk_err is sticky; cleared only by reset.
- Register write and PC update are independent and may coincide in the same cycle (e.g. call while writing a register).
- Latency: one cycle for all state updates; opcode is available in the same cycle as instr.

Optional Feature:
CARRY_FLAG_EN
- Defined: c <= carry-out of A+B (op 010) or borrow of A-B (op 011), on the same edges z updates. Other ops clear c on those edges.
- Undefined: c is constant 0 and no carry logic is synthesised. The port stays present in both builds.

Decomposition:
- Package microc_pkg: ALU op localparams (ALU_PASS, ALU_NOT, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NEGA, ALU_NEGB) and the opcode width constant 6.
- Sub-module microc_stack: parametrised LIFO (width PCW, depth SDEPTH) with push, pop, full, empty and top outputs.
- ALU and register file stay inline.

Test Plan:
- Reset, then s_inc=1, s_inm=1, we3=1, imm=0x2A, wa3=3 -> pc=1, R3=0x2A; z unchanged at 0.
- R1=0x05, R2=0x05, op=011, we3=1, s_inm=0 -> written value 0x00, z=1; then op=010 on same operands -> 0x0A, z=0.
- s_inc=0, jaddr=0x155 -> pc=0x155; with pc=0x3FF and s_inc=1 -> pc=0x000.
- Nested calls at pc=5 then pc=0x20 to 0x100, then two s_ret -> pc sequence 0x100, ..., 0x21, 6; stk_err=0.
- 5 calls with SDEPTH=4 -> stk_err=1 after the 5th, 4 rets return correctly. A further ret on empty -> pc+1, stk_err stays 1 until reset.
- CARRY_FLAG_EN defined: 0xFF+0x01 -> result 0x00, z=1, c=1. Undefined build: same stimulus -> c=0.
